// File: rtl/int_ram_pkg.sv
// Shared types, default sizes and helpers for the big-integer RAM readers.
package int_ram_pkg;

  localparam int DEF_MEM_WIDTH    = 8;
  localparam int DEF_MEM_WORDS    = 129;
  localparam int DEF_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FLUSH
  } rd_state_t;

  // Next address with wrap at an arbitrary depth (not a power-of-2 modulo).
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned words);
    if (addr + 32'd1 >= words) begin
      return 32'd0;
    end
    return addr + 32'd1;
  endfunction

endpackage

// File: rtl/int_ram_rd_fifo.sv
// Small synchronous register FIFO: head comes straight from storage registers,
// with a synchronous clear and an occupancy count.
module int_ram_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop frees a slot in the same cycle, so push-while-full is allowed then.
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

  // Storage write; entries reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push && !clr) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign valid = (r_count != '0);
  assign count = r_count;

endmodule

// File: rtl/int_ram_reader.sv
// Streams a run of consecutive RAM words out as a valid/ready stream,
// hiding the RAM read latency behind a credit-limited skid FIFO.
module int_ram_reader
  import int_ram_pkg::*;
#(
  parameter int MEM_WIDTH    = DEF_MEM_WIDTH,
  parameter int MEM_WORDS    = DEF_MEM_WORDS,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  localparam int AW         = $clog2(MEM_WORDS),
  localparam int LW         = $clog2(MEM_WORDS + 1),
  localparam int FIFO_DEPTH = READ_LATENCY + 2,
  localparam int CW         = $clog2(FIFO_DEPTH + 1),
  localparam int FW         = $clog2(READ_LATENCY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [LW-1:0]        length,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        ram_address,
  output logic                 ram_rden,
  input  logic [MEM_WIDTH-1:0] ram_q,
  output logic [MEM_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  rd_state_t             r_state;
  rd_state_t             w_state_next;
  logic [AW-1:0]         r_addr;
  logic [AW-1:0]         r_ram_address;
  logic [LW-1:0]         r_remain;
  logic [CW-1:0]         r_credits;
  logic [FW-1:0]         r_flush_cnt;
  logic                  r_rden;
  logic                  r_rden_last;
  logic                  r_done;
  logic [READ_LATENCY-1:0] r_lat_vld;
  logic [READ_LATENCY-1:0] r_lat_last;

  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_clear;
  logic                  w_load;
  logic                  w_done_next;
  logic [MEM_WIDTH:0]    w_fifo_head;
  logic                  w_fifo_valid;
  logic [CW-1:0]         w_fifo_count;

  assign w_pop = w_fifo_valid & out_ready;

  // Issue when a credit is free; a pop in the same cycle frees one, which
  // keeps one word per cycle flowing with a full credit pool.
  assign w_issue      = (r_state == ST_ISSUE) && !abort &&
                        ((r_credits < CW'(FIFO_DEPTH)) || w_pop);
  assign w_last_issue = w_issue && (r_remain == LW'(1));
  assign w_push       = r_lat_vld[READ_LATENCY-1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            w_load       = 1'b1;
            w_state_next = ST_ISSUE;
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          w_clear      = 1'b1;
          w_state_next = ST_FLUSH;
        end else if (w_last_issue) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          w_clear      = 1'b1;
          w_state_next = ST_FLUSH;
        end else if (w_pop && w_fifo_head[MEM_WIDTH]) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == '0) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Address, remaining-word count and registered RAM request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr        <= '0;
      r_ram_address <= '0;
      r_remain      <= '0;
      r_rden        <= 1'b0;
      r_rden_last   <= 1'b0;
    end else begin
      r_rden      <= w_issue;
      r_rden_last <= w_last_issue;
      if (w_load) begin
        r_addr   <= start_addr;
        r_remain <= length;
      end else if (w_issue) begin
        r_ram_address <= r_addr;
        r_addr        <= AW'(wrap_inc(32'(r_addr), $unsigned(MEM_WORDS)));
        r_remain      <= r_remain - LW'(1);
      end
    end
  end

  // Credits: words issued but not yet popped from the stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= '0;
    end else if (w_clear) begin
      r_credits <= '0;
    end else if (w_issue && !w_pop) begin
      r_credits <= r_credits + CW'(1);
    end else if (!w_issue && w_pop) begin
      r_credits <= r_credits - CW'(1);
    end
  end

  // Return-path tracker aligned with ram_q; cleared on abort so in-flight
  // data is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_vld  <= '0;
      r_lat_last <= '0;
    end else if (w_clear) begin
      r_lat_vld  <= '0;
      r_lat_last <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        r_lat_vld[i]  <= r_lat_vld[i-1];
        r_lat_last[i] <= r_lat_last[i-1];
      end
      r_lat_vld[0]  <= r_rden;
      r_lat_last[0] <= r_rden_last;
    end
  end

  // FLUSH dwell counter, loaded on abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else if (w_clear) begin
      r_flush_cnt <= FW'(READ_LATENCY - 1);
    end else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0)) begin
      r_flush_cnt <= r_flush_cnt - FW'(1);
    end
  end

  // Completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_next;
    end
  end

  int_ram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MEM_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_clear),
    .push      (w_push),
    .push_data ({r_lat_last[READ_LATENCY-1], ram_q}),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .valid     (w_fifo_valid),
    .count     (w_fifo_count)
  );

  // Every FIFO entry was paid for with a credit.
  a_fifo_within_credits : assert property (
    @(posedge clk) disable iff (rst) (w_fifo_count <= r_credits)
  );

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign ram_address = r_ram_address;
  assign ram_rden    = r_rden;
  assign out_data    = w_fifo_head[MEM_WIDTH-1:0];
  assign out_valid   = w_fifo_valid;
  assign out_last    = w_fifo_valid & w_fifo_head[MEM_WIDTH];

endmodule

// File: tb/tb_int_ram_reader.sv
// Directed bench for int_ram_reader with a RAM model, an expected-word queue
// and a per-cycle compare process.
module tb_int_ram_reader;

  localparam int WORDS = 129;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] start_addr = '0;
  logic [7:0] length = '0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] ram_address;
  logic       ram_rden;
  logic [7:0] ram_q = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;

  int_ram_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_addr  (start_addr),
    .length      (length),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .ram_address (ram_address),
    .ram_rden    (ram_rden),
    .ram_q       (ram_q),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: registered address then registered output (two cycles).
  logic [7:0] mem [WORDS];
  logic [7:0] ram_a1 = '0;
  logic       ram_v1 = 1'b0;
  always @(posedge clk) begin
    ram_v1 <= ram_rden;
    ram_a1 <= ram_address;
    if (ram_v1) ram_q <= mem[ram_a1];
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected stream model and per-transfer statistics.
  logic [8:0] exp_q[$];
  int         exp_addr_q[$];
  int t0 = 0;
  int rden_count, acc_count, last_count, valid_count, done_count;
  int first_valid_rel, last_acc_rel, done_rel, max_out;
  logic [7:0] first_data, last_data;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word = '0;

  int rmode = 0;
  int rphase = 0;

  task automatic clear_stats();
    rden_count = 0; acc_count = 0; last_count = 0; valid_count = 0;
    done_count = 0; first_valid_rel = -1; last_acc_rel = -1; done_rel = -1;
    max_out = 0; first_data = '0; last_data = '0;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = (mode == 0) ? 8'(i) : 8'((i * 7 + 3) & 255);
    end
  endtask

  // Queue the words a transfer must produce, then pulse start.
  task automatic start_xfer(input int sa, input int len, input logic with_abort);
    int a;
    clear_stats();
    for (int k = 0; k < len; k++) begin
      a = (sa + k) % WORDS;
      exp_addr_q.push_back(a);
      exp_q.push_back({(k == len - 1) ? 1'b1 : 1'b0, mem[a]});
    end
    @(posedge clk); #1;
    start = 1'b1; start_addr = 8'(sa); length = 8'(len); abort = with_abort;
    t0 = cyc + 1;
    $display("xfer start addr=%0d len=%0d abort=%0b", sa, len, with_abort);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_count > 0) break;
    end
    check("done_seen", (done_count > 0) ? 1 : 0, 1);
    $display("xfer end words=%0d done_rel=%0d", acc_count, done_rel);
  endtask

  // Stream ready pattern: always high, or 1,0,0,1 repeating.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rmode == 0) out_ready = 1'b1;
      else begin
        out_ready = ((rphase % 4) == 0) || ((rphase % 4) == 3);
        rphase++;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    int rel, a;
    logic [8:0] w;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        rel = cyc - t0;
        if (ram_rden) begin
          rden_count++;
          if (exp_addr_q.size() == 0) check("rden_expected", 0, 1);
          else begin
            a = exp_addr_q.pop_front();
            check("rd_addr", 32'(ram_address), 32'(a));
          end
          if (rden_count - acc_count > max_out) max_out = rden_count - acc_count;
        end
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 1);
          check("stall_word", 32'({out_last, out_data}), 32'(prev_word));
        end
        if (out_valid) begin
          valid_count++;
          if (first_valid_rel < 0) first_valid_rel = rel;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("word_expected", 0, 1);
          else begin
            w = exp_q.pop_front();
            check("word", 32'({out_last, out_data}), 32'(w));
          end
          if (acc_count == 0) first_data = out_data;
          last_data = out_data;
          acc_count++;
          last_acc_rel = rel;
          if (out_last) last_count++;
        end
        if (done) begin
          done_count++;
          if (done_count == 1) done_rel = rel;
          check("busy_low_at_done", 32'(busy), 0);
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_last, out_data};
        if (abort && busy) begin
          exp_q.delete();
          exp_addr_q.delete();
          prev_stall = 1'b0;
        end
      end
    end
  end

  initial begin
    int n, ta;
    clear_stats();
    fill(0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rden", 32'(ram_rden), 0);
    check("rst_addr", 32'(ram_address), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_data", 32'(out_data), 0);
    rst = 1'b0;

    // Full-depth transfer, ready always high.
    start_xfer(0, 129, 1'b0);
    wait_done(300);
    check("t1_first_valid_cycle", 32'(first_valid_rel), 4);
    check("t1_last_accept_cycle", 32'(last_acc_rel), 132);
    check("t1_done_cycle", 32'(done_rel), 133);
    check("t1_words", 32'(acc_count), 129);
    check("t1_last_count", 32'(last_count), 1);
    check("t1_first_data", 32'(first_data), 0);
    check("t1_last_data", 32'(last_data), 128);
    check("t1_queue_empty", 32'(exp_q.size()), 0);

    // Address wrap across MEM_WORDS-1 -> 0.
    fill(1);
    start_xfer(126, 5, 1'b0);
    wait_done(100);
    check("t2_done_cycle", 32'(done_rel), 9);
    check("t2_words", 32'(acc_count), 5);
    check("t2_first_data", 32'(first_data), 117);
    check("t2_last_data", 32'(last_data), 10);
    check("t2_addr_queue_empty", 32'(exp_addr_q.size()), 0);

    // Backpressure pattern 1,0,0,1.
    rmode = 1; rphase = 0;
    start_xfer(40, 10, 1'b0);
    wait_done(200);
    check("t3_words", 32'(acc_count), 10);
    check("t3_last_count", 32'(last_count), 1);
    check("t3_max_outstanding_le4", (max_out <= 4) ? 1 : 0, 1);
    check("t3_queue_empty", 32'(exp_q.size()), 0);
    rmode = 0;

    // Zero-length request.
    start_xfer(7, 0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("t4_done_cycle", 32'(done_rel), 0);
    check("t4_done_count", 32'(done_count), 1);
    check("t4_rden_count", 32'(rden_count), 0);
    check("t4_valid_count", 32'(valid_count), 0);

    // Abort on the 8th read.
    start_xfer(20, 20, 1'b0);
    n = 0; ta = -1;
    for (int i = 0; i < 200; i++) begin
      if (ram_rden) n++;
      if (n == 8) begin
        abort = 1'b1;
        ta = cyc;
        $display("abort at cycle %0d", ta);
        @(posedge clk); #1;
        abort = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    check("t5_abort_reached", (ta >= 0) ? 1 : 0, 1);
    check("t5_valid_after_abort", 32'(out_valid), 0);
    check("t5_rden_after_abort", 32'(ram_rden), 0);
    check("t5_busy_flush1", 32'(busy), 1);
    @(posedge clk); #1;
    check("t5_busy_flush2", 32'(busy), 1);
    @(posedge clk); #1;
    check("t5_busy_idle", 32'(busy), 0);
    repeat (6) @(posedge clk);
    #1;
    check("t5_no_done", 32'(done_count), 0);
    check("t5_no_valid", 32'(out_valid), 0);
    start_xfer(50, 6, 1'b0);
    wait_done(100);
    check("t5_restart_done_cycle", 32'(done_rel), 10);
    check("t5_restart_words", 32'(acc_count), 6);
    check("t5_restart_first_data", 32'(first_data), 97);

    // Asynchronous reset mid-transfer.
    start_xfer(100, 30, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_done", 32'(done), 0);
    check("t6_rden", 32'(ram_rden), 0);
    check("t6_addr", 32'(ram_address), 0);
    check("t6_valid", 32'(out_valid), 0);
    check("t6_data", 32'(out_data), 0);
    check("t6_last", 32'(out_last), 0);
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    // Short transfer after reset, start and abort together in IDLE.
    start_xfer(10, 3, 1'b1);
    wait_done(100);
    check("t7_done_cycle", 32'(done_rel), 7);
    check("t7_words", 32'(acc_count), 3);
    check("t7_first_data", 32'(first_data), 73);
    check("t7_last_count", 32'(last_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/int_ram_reader.md
# int_ram_reader

Streams a run of consecutive words out of one port of the dual-port big-integer RAM used by the RSA datapath. It presents a valid/ready stream to the modular-arithmetic units. The block issues RAM reads and absorbs the fixed RAM read latency. It uses a credit-limited skid FIFO so downstream backpressure never loses a word. One instance sits on each RAM port that feeds a consumer; writers use the other port.

## Interface
- MEM_WIDTH, 8: word width in bits; must match the RAM.
- MEM_WORDS, 129: RAM depth in words; addresses are 0..MEM_WORDS-1.
- READ_LATENCY, 2: cycles from the address-presented cycle to the cycle `ram_q` holds data (registered address plus registered output).
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  $clog2(MEM_WORDS)  first word address; must be < MEM_WORDS.
- length  in  $clog2(MEM_WORDS+1)  word count, 0..MEM_WORDS.
- abort  in  1  cancels the current transfer; ignored in IDLE and FLUSH.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.
- ram_address  out  $clog2(MEM_WORDS)  registered RAM address.
- ram_rden  out  1  registered read enable, one word per high cycle.
- ram_q  in  MEM_WIDTH  RAM read data.
- out_data  out  MEM_WIDTH  stream data (FIFO head).
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  high with the final word of the transfer.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE:
  - start with length > 0: latch address and count, go to ISSUE.
  - start with length = 0: pulse `done` next cycle, stay IDLE, issue no reads.
- ISSUE:
  - Each cycle where credits < FIFO_DEPTH, drive `ram_rden` = 1 with the current address, then advance the address.
  - Address wraps from MEM_WORDS-1 to 0; it is not a power-of-2 modulo.
  - When the final read is issued, go to DRAIN.
- DRAIN: wait until the handshake (out_valid & out_ready & out_last) completes, then go to IDLE and pulse `done`.
- Return path:
  - A shift register of depth READ_LATENCY tracks ram_rden and a last tag.
  - Its output pushes ram_q and the last tag into the FIFO.
- Credit counter, 0..FIFO_DEPTH:
  - +1 on issue, −1 on pop, unchanged when both happen.
  - The issue decision uses the registered count.
- FIFO_DEPTH = READ_LATENCY + 2. This gives 1 word/cycle sustained with out_ready high, and the FIFO never overflows.
- abort in ISSUE or DRAIN:
  - Stop issuing and clear the FIFO and credits.
  - Enter FLUSH for READ_LATENCY cycles, dropping all returning data, then IDLE.
  - `done` is not pulsed; out_valid = 0 from the cycle after abort.
- start during busy is ignored. abort and start in the same IDLE cycle: start wins.
- Reset values: all outputs 0, state IDLE, FIFO empty, credits 0, address 0.

## Timing
- start sampled at edge 0:
  - first `ram_rden` in cycle 1;
  - first `out_valid` in cycle READ_LATENCY+2, i.e. 4 with defaults.
- With out_ready held high, an N-word transfer:
  - last word accepted in cycle N+READ_LATENCY+1;
  - `done` in the following cycle;
  - `busy` falls in the same cycle `done` rises.
- out_data/out_valid/out_last come straight from FIFO registers; there is no combinational path from out_ready.
- out_valid, once high, stays high with stable data until accepted.
- Reset mid-transfer: all state clears immediately; in-flight RAM data is ignored.

## Structure
- Shared package `int_ram_pkg`:
  - reader state enum;
  - default MEM_WIDTH/MEM_WORDS/READ_LATENCY constants;
  - address-wrap helper function.
- One sub-module, `int_ram_rd_fifo`: a parameterised synchronous register FIFO (depth, width, count output, clear input).
- The top level holds the FSM, address/count/credit counters and the latency shift register.

## Test plan
- length=129, start_addr=0, out_ready=1, RAM[i]=i:
  - words 0..128 arrive on consecutive cycles, first word in cycle 4;
  - out_last only on 128;
  - done in cycle 133.
- length=5, start_addr=126: addresses 126,127,128,0,1 in order; out_last on the word from address 1.
- length=10 with out_ready toggled 1,0,0,1 repeating:
  - all 10 words delivered once, in order;
  - credits never exceed 4;
  - data stable while stalled.
- length=0: done pulses the cycle after start; ram_rden and out_valid never assert.
- length=20, abort asserted on the 8th ram_rden:
  - out_valid low the next cycle;
  - busy low after 2 FLUSH cycles;
  - no done;
  - a new start then streams correctly.
- rst asserted mid-transfer, asynchronously between edges: all outputs 0 immediately; a later length=3 transfer behaves normally.
